signed_multiplier: RTL and testbench

//   Multi-cycle two's-complement multiplier for the accelerator datapath.

---
 rtl/signed_multiplier.sv | 136 +++++++++++++
 tb/tb_signed_multiplier.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/signed_multiplier.sv
// Multi-cycle two's-complement multiplier.
// Operands are converted to sign-magnitude on accept, the magnitudes are
// multiplied with a one-bit-per-cycle shift-add engine, and the sign is
// re-applied when the result is published.
module signed_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Unsigned magnitude of a two's-complement value; the most negative value
  // maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic                 sign_q, sign_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH-1:0]   mag_s;

  // Next-state and datapath: the multiplier magnitude lives in the low half
  // of the accumulator and is consumed LSB first as the partial sums shift in.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    mag_s = acc_q[2*WIDTH-1:0];

    case (state_q)
      IDLE: begin
        // busy_q is still high during the done cycle, so a start presented
        // there is dropped rather than accepted.
        if (start && !busy_q) begin
          state_d = CALC;
          mcand_d = magnitude(a);
          acc_d   = {{(WIDTH+1){1'b0}}, magnitude(b)};
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      CALC: begin
        if (acc_q[0]) begin
          acc_d = {sum_s, acc_q[WIDTH-1:0]} >> 1;
        end else begin
          acc_d = acc_q >> 1;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        // A zero magnitude is published as +0 regardless of sign.
        if (sign_q && (mag_s != {(2*WIDTH){1'b0}})) begin
          product_d = -mag_s;
        end else begin
          product_d = mag_s;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      mcand_q   <= {WIDTH{1'b0}};
      acc_q     <= {AW{1'b0}};
      sign_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= {(2*WIDTH){1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      sign_q    <= sign_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_signed_multiplier.sv
// Self-checking bench for signed_multiplier (WIDTH=16): directed corner
// cases, ignored re-start, mid-operation reset and random operand pairs
// compared against plain signed arithmetic.
module tb_signed_multiplier;

  localparam int W = 16;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  signed_multiplier #(.WIDTH(W)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed product using wide integer arithmetic.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    longint px;
    longint py;
    longint pr;
    px = longint'($signed(x));
    py = longint'($signed(y));
    pr = px * py;
    ref_mul = pr[2*W-1:0];
  endfunction

  // Present operands with a one-cycle start; returns just after the accept edge
  // with the operand inputs scrambled.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Count rising edges until done is seen, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat;
    launch(av, bv);
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_product"}, 64'(product), 64'(ref_mul(av, bv)));
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [2*W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    n_rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    // Directed corner cases.
    op("p3xm5", 16'h0003, 16'hFFFB);
    check("p3xm5_value", 64'(product), 64'hFFFF_FFF1);
    op("min_min", 16'h8000, 16'h8000);
    check("min_min_value", 64'(product), 64'h4000_0000);
    op("min_max", 16'h8000, 16'h7FFF);
    check("min_max_value", 64'(product), 64'hC000_8000);
    op("zero_neg", 16'h0000, 16'hFFFF);
    check("zero_neg_value", 64'(product), 64'h0000_0000);
    op("m1_m1", 16'hFFFF, 16'hFFFF);
    check("m1_m1_value", 64'(product), 64'h0000_0001);
    op("max_max", 16'h7FFF, 16'h7FFF);
    check("max_max_value", 64'(product), 64'h3FFF_0001);

    // Start re-pulsed during CALC is ignored; result is held afterwards.
    launch(16'd100, 16'hFFF9);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 16'h1234;
    b = 16'h0055;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("repulse_latency", 64'(lat), 64'd12);
    check("repulse_product", 64'(product), 64'(ref_mul(16'd100, 16'hFFF9)));
    held = product;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
      check("repulse_hold", 64'(product), 64'(held));
    end
    check("repulse_no_second_done", 64'(seen), 64'd0);
    check("repulse_idle", 64'(busy), 64'd0);

    // Reset in the middle of a calculation aborts it.
    launch(16'd1234, 16'hFFFD);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("abort_quiet", 64'(seen), 64'd0);
    check("abort_product_held", 64'(product), 64'd0);
    op("after_abort", 16'hFF00, 16'h0123);

    // Random operand pairs.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      launch(ra, rb);
      wait_done(lat);
      check("rand_latency", 64'(lat), 64'(LAT));
      check("rand_product", 64'(product), 64'(ref_mul(ra, rb)));
      @(posedge clk);
      #1;
      check("rand_idle", 64'(busy), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
